// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a 2-entry skid FIFO on the output.
// Instructions arrive over valid/ready. Each one is decoded to a format code and an
// immediate sign- or zero-extended to XLEN. Results leave over valid/ready.
// in_ready is a function of registered occupancy only, so back-pressure never forms a
// combinational path from out_ready to in_ready.
module imm_gen_pipe #(
  parameter int unsigned XLEN         = 32,
  parameter bit          ENABLE_ZICSR = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] FMT_NONE    = 3'd0;
  localparam logic [2:0] FMT_I       = 3'd1;
  localparam logic [2:0] FMT_S       = 3'd2;
  localparam logic [2:0] FMT_B       = 3'd3;
  localparam logic [2:0] FMT_U       = 3'd4;
  localparam logic [2:0] FMT_J       = 3'd5;
  localparam logic [2:0] FMT_Z       = 3'd6;
  localparam logic [2:0] FMT_ILLEGAL = 3'd7;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_z;
  logic [XLEN-1:0] imm_shamt;
  logic [XLEN-1:0] imm_shamt_w;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  // Second (skid) entry; the head entry lives directly in the out_* registers.
  logic            tail_valid;
  logic [XLEN-1:0] tail_imm;
  logic [2:0]      tail_fmt;
  logic            tail_ill;

  logic push;
  logic pop;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0}));
  assign imm_z = XLEN'(in_instr[19:15]);

  // Shift amounts exclude funct7; RV64 OP-IMM uses a 6-bit shamt, word shifts use 5 bits.
  assign imm_shamt   = IS_RV64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
  assign imm_shamt_w = XLEN'(in_instr[24:20]);

  // Full occupancy is exactly "tail holds an entry", which is a registered bit.
  assign in_ready = ~tail_valid;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Decode format and immediate of the incoming instruction.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_ILLEGAL;
    dec_ill = 1'b1;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP, OPC_FENCE: begin
          dec_fmt = FMT_NONE;
          dec_ill = 1'b0;
        end
        OPC_OP_IMM: begin
          dec_fmt = FMT_I;
          dec_ill = 1'b0;
          dec_imm = is_shift ? imm_shamt : imm_i;
        end
        OPC_LOAD, OPC_JALR: begin
          dec_fmt = FMT_I;
          dec_ill = 1'b0;
          dec_imm = imm_i;
        end
        OPC_STORE: begin
          dec_fmt = FMT_S;
          dec_ill = 1'b0;
          dec_imm = imm_s;
        end
        OPC_BRANCH: begin
          dec_fmt = FMT_B;
          dec_ill = 1'b0;
          dec_imm = imm_b;
        end
        OPC_LUI, OPC_AUIPC: begin
          dec_fmt = FMT_U;
          dec_ill = 1'b0;
          dec_imm = imm_u;
        end
        OPC_JAL: begin
          dec_fmt = FMT_J;
          dec_ill = 1'b0;
          dec_imm = imm_j;
        end
        OPC_SYSTEM: begin
          dec_ill = 1'b0;
          if (ENABLE_ZICSR && funct3[2]) begin
            dec_fmt = FMT_Z;
            dec_imm = imm_z;
          end else begin
            dec_fmt = FMT_NONE;
          end
        end
        OPC_OP_IMM_32: begin
          if (IS_RV64) begin
            dec_fmt = FMT_I;
            dec_ill = 1'b0;
            dec_imm = is_shift ? imm_shamt_w : imm_i;
          end
        end
        OPC_OP_32: begin
          if (IS_RV64) begin
            dec_fmt = FMT_NONE;
            dec_ill = 1'b0;
          end
        end
        default: begin
          dec_fmt = FMT_ILLEGAL;
        end
      endcase
    end
  end

  // Two-entry FIFO: head drives out_*, tail absorbs one extra entry while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_illegal <= 1'b0;
      tail_valid  <= 1'b0;
      tail_imm    <= '0;
      tail_fmt    <= FMT_NONE;
      tail_ill    <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      tail_valid <= 1'b0;
    end else if (pop) begin
      // A full FIFO cannot push, so tail promotion and push never coincide.
      if (tail_valid) begin
        out_imm     <= tail_imm;
        out_fmt     <= tail_fmt;
        out_illegal <= tail_ill;
        tail_valid  <= 1'b0;
      end else if (push) begin
        out_imm     <= dec_imm;
        out_fmt     <= dec_fmt;
        out_illegal <= dec_ill;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      if (!out_valid) begin
        out_valid   <= 1'b1;
        out_imm     <= dec_imm;
        out_fmt     <= dec_fmt;
        out_illegal <= dec_ill;
      end else begin
        tail_valid <= 1'b1;
        tail_imm   <= dec_imm;
        tail_fmt   <= dec_fmt;
        tail_ill   <= dec_ill;
      end
    end
  end

  // Saturating count of accepted illegal instructions; flush does not undo it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (push && dec_ill && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe. An RV32 instance (16-bit counter)
// and an RV64 instance (3-bit counter) share one input stream; each accepted instruction
// pushes the reference decode for both widths, and a monitor pops on every output transfer.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        out_ready = 1'b1;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a;
  logic [2:0]  out_fmt_a;
  logic [15:0] illegal_cnt_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_b;
  logic [2:0]  illegal_cnt_b;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .ENABLE_ZICSR(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a),
    .illegal_cnt(illegal_cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .ENABLE_ZICSR(1'b1), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b),
    .illegal_cnt(illegal_cnt_b)
  );

  typedef struct {
    logic [63:0] imm_a;
    logic [2:0]  fmt_a;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   occ = 0;
  int   cnt_a = 0;
  int   cnt_b = 0;
  bit   was_reset = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sext(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  // Reference decode written from the field layouts, using integer arithmetic.
  function automatic void model(input logic [31:0] i, input int xlen,
                                output logic [63:0] imm, output logic [2:0] fmt);
    longint v = 0;
    int     op = int'(i[6:0]);
    int     f3 = int'(i[14:12]);
    bit     shift = (f3 == 1) || (f3 == 5);
    fmt = 3'd7;
    case (op)
      'h33, 'h0F: fmt = 3'd0;
      'h13: begin
        fmt = 3'd1;
        if (shift) v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
        else v = sext(longint'(i[31:20]), 12);
      end
      'h03, 'h67: begin fmt = 3'd1; v = sext(longint'(i[31:20]), 12); end
      'h23: begin fmt = 3'd2; v = sext(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12); end
      'h63: begin
        fmt = 3'd3;
        v = sext(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                 longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
      end
      'h37, 'h17: begin fmt = 3'd4; v = sext(longint'(i[31:12]) * 4096, 32); end
      'h6F: begin
        fmt = 3'd5;
        v = sext(longint'(i[31]) * (longint'(1) << 20) + longint'(i[19:12]) * 4096 +
                 longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
      end
      'h73: begin
        if (f3 >= 4) begin fmt = 3'd6; v = longint'(i[19:15]); end
        else fmt = 3'd0;
      end
      'h1B: if (xlen == 64) begin
        fmt = 3'd1;
        v = shift ? longint'(i[24:20]) : sext(longint'(i[31:20]), 12);
      end
      'h3B: if (xlen == 64) fmt = 3'd0;
      default: fmt = 3'd7;
    endcase
    imm = 64'(v);
    if (xlen == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
  endfunction

  // One clock of stimulus; at the following negedge, check state then account for the next edge.
  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] ins, input bit ordy);
    exp_t e;
    bit   acc;
    bit   pp;
    @(posedge clk);
    #1;
    rst_n = r; flush = f; in_valid = v; in_instr = ins; out_ready = ordy;
    @(negedge clk);
    if (was_reset) begin
      check("rst_out_valid", 64'(out_valid_a), 64'd0);
      check("rst_out_imm", 64'(out_imm_a), 64'd0);
      check("rst_out_fmt", 64'(out_fmt_a), 64'd0);
      check("rst_out_illegal", 64'(out_illegal_a), 64'd0);
      check("rst_out_imm64", out_imm_b, 64'd0);
      was_reset = 1'b0;
    end
    check("in_ready_a", 64'(in_ready_a), 64'(occ < 2));
    check("in_ready_b", 64'(in_ready_b), 64'(occ < 2));
    check("out_valid_a", 64'(out_valid_a), 64'(occ > 0));
    check("illegal_cnt_a", 64'(illegal_cnt_a), 64'(cnt_a));
    check("illegal_cnt_b", 64'(illegal_cnt_b), 64'(cnt_b));
    if (!r) begin
      occ = 0; cnt_a = 0; cnt_b = 0; was_reset = 1'b1;
      sb.delete();
    end else begin
      acc = v && (occ < 2);
      pp  = (occ > 0) && ordy;
      if (acc) begin
        model(ins, 32, e.imm_a, e.fmt_a);
        model(ins, 64, e.imm_b, e.fmt_b);
        if (e.fmt_a == 3'd7 && cnt_a < 65535) cnt_a++;
        if (e.fmt_b == 3'd7 && cnt_b < 7) cnt_b++;
      end
      if (f) begin
        occ = 0;
        sb.delete();
      end else begin
        if (acc) sb.push_back(e);
        occ = occ + int'(acc) - int'(pp);
      end
    end
  endtask

  // Monitor: every output transfer is compared against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !flush && out_valid_a && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got imm 0x%0h fmt %0d, expected no output", out_imm_a, out_fmt_a);
        end else begin
          e = sb.pop_front();
          check("out_imm_a", 64'(out_imm_a), e.imm_a);
          check("out_fmt_a", 64'(out_fmt_a), 64'(e.fmt_a));
          check("out_illegal_a", 64'(out_illegal_a), 64'(e.fmt_a == 3'd7));
          check("out_valid_b", 64'(out_valid_b), 64'd1);
          check("out_imm_b", out_imm_b, e.imm_b);
          check("out_fmt_b", 64'(out_fmt_b), 64'(e.fmt_b));
          check("out_illegal_b", 64'(out_illegal_b), 64'(e.fmt_b == 3'd7));
        end
      end
    end
  end

  logic [6:0] ops [13] = '{7'h33, 7'h0F, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h73, 7'h1B, 7'h3B};

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 13);
    if (k < 13) w[6:0] = ops[k];
    return w;
  endfunction

  initial begin
    bit f;
    bit v;
    // Reset
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    // Directed decode cases
    step(1'b1, 1'b0, 1'b1, 32'hFFF00093, 1'b1);  // addi -1
    step(1'b1, 1'b0, 1'b1, 32'h4030D093, 1'b1);  // srai 3
    step(1'b1, 1'b0, 1'b1, 32'hFE000EE3, 1'b1);  // beq -4
    step(1'b1, 1'b0, 1'b1, 32'h300FD073, 1'b1);  // csrrwi zimm 31
    step(1'b1, 1'b0, 1'b1, 32'h800000B7, 1'b1);  // lui
    step(1'b1, 1'b0, 1'b1, 32'h0000001B, 1'b1);  // OP-IMM-32: illegal on RV32
    step(1'b1, 1'b0, 1'b1, 32'h00000032, 1'b1);  // low bits != 11
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    // Back-pressure: A, B fill the FIFO, C is held off until a pop
    step(1'b1, 1'b0, 1'b1, 32'h00500113, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h00112423, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h008000EF, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h008000EF, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h008000EF, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h008000EF, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    // Flush while full with a legal input offered
    step(1'b1, 1'b0, 1'b1, 32'h00A00093, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h00B00093, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h00C00093, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    // Counter saturation on the 3-bit instance
    repeat (10) step(1'b1, 1'b0, 1'b1, 32'h0000007F, 1'b1);
    // Reset mid-stream
    step(1'b1, 1'b0, 1'b1, 32'h12345037, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hFFFFF06F, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h00100093, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      f = ($urandom_range(0, 49) == 0);
      v = !f && ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 299) != 0), f, v, gen_instr(), ($urandom_range(0, 3) != 0));
    end
    // Drain
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
